step_control: RTL and testbench
===============================

STEP_CONTROL -- requirements
Module: step_control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples needed to accept a key level.
REQ-002 Parameter RUN_DIV, default 25000000, is the period in clock cycles between enables in RUN mode.
REQ-003 Port clock, input, 1 bit: the single system clock; all logic is rising-edge triggered.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port key_step_n, input, 1 bit: raw pushbutton, active-low; each press requests one processor step.
REQ-006 Port key_run_n, input, 1 bit: raw pushbutton, active-low; each press toggles free-run.
REQ-007 Port halt_req, input, 1 bit: processor halt indication, active-high level.
REQ-008 Port cpu_en, output, 1 bit: registered clock-enable to the processor, at most one cycle wide per step.
REQ-009 Port mode, output, 2 bits: current state code (STOP=0, STEP=1, RUN=2, HALT=3).
REQ-010 Port step_count, output, 16 bits: number of cpu_en pulses issued since reset.

Function
REQ-011 Each key SHALL pass through a 2-flop synchronizer, then a debouncer holding a stable level (reset value 1 = released).
REQ-012 The debouncer SHALL update its stable level only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any shorter excursion restarts the count and SHALL be ignored.
REQ-013 A press event SHALL be a single-cycle pulse when the stable level goes 1->0; release (0->1) SHALL NOT generate an event; a held key SHALL produce exactly one event.
REQ-014 STOP: cpu_en=0; run event -> RUN; else step event -> STEP; run has priority on a simultaneous step event.
REQ-015 STEP: cpu_en=1 for exactly that one cycle, then unconditionally -> STOP.
REQ-016 RUN: a divider SHALL count 0..RUN_DIV-1, wrapping to 0; cpu_en=1 only in the cycle the count equals RUN_DIV-1.
REQ-017 RUN: a run event -> STOP and clears the divider; step events SHALL be ignored.
REQ-018 halt_req=1 in any state SHALL force HALT on the next edge; cpu_en SHALL be 0 in any cycle where halt_req=1; halt has priority over all key events.
REQ-019 HALT: cpu_en=0; step events are ignored; a run event while halt_req=0 -> STOP.
REQ-020 cpu_en SHALL be registered and SHALL rise exactly one cycle after the press event that causes STEP.
REQ-021 step_count SHALL increment by 1 in the cycle after every cpu_en=1 cycle and wrap 0xFFFF -> 0x0000.
REQ-022 The divider SHALL hold at 0 in every state except RUN and restart from 0 on each RUN entry.

Reset
REQ-023 reset=0 SHALL asynchronously force mode=STOP, cpu_en=0, step_count=0, divider=0, synchronizer flops and stable levels=1, and debounce counts=0.
REQ-024 Asserting reset during RUN or STEP SHALL drop cpu_en immediately, without waiting for a clock edge.
REQ-025 After reset deasserts, no press event SHALL occur unless a key goes from released to pressed.

Structure
REQ-026 The state codes STOP/STEP/RUN/HALT SHALL be defined once in the shared processor control package, proc_ctrl_pkg.
REQ-027 Synchronizer, debouncer and edge detection SHALL be one sub-module, key_debounce, instantiated once per key.
REQ-028 The FSM, divider and step counter SHALL reside in step_control.

Verification
REQ-029 With DEBOUNCE_CYCLES=4 in STOP, press key_step_n for 20 cycles -> exactly one cpu_en pulse, step_count=1, mode returns to 0.
REQ-030 Bounce key_step_n low for 3 cycles, then high -> no event and cpu_en stays 0.
REQ-031 With RUN_DIV=5, press run -> cpu_en on every 5th cycle; after 4 pulses step_count=4; press run again -> STOP and no further pulses.
REQ-032 In RUN, raise halt_req in the cycle the divider reaches 4 -> cpu_en=0 and mode=3; a run press while halt_req=1 is ignored; drop halt_req, then press run -> mode=0.
REQ-033 Preload step_count=0xFFFF via 65535 steps, then issue one more step -> step_count=0x0000.
REQ-034 Assert reset mid-RUN between edges -> cpu_en=0 and mode=0 immediately; key_step_n held low through reset release -> no event.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: shared processor-control state codes, widths and sizing helper
package proc_ctrl_pkg;
  typedef enum logic [1:0] {STOP = 2'd0, STEP = 2'd1, RUN = 2'd2, HALT = 2'd3} proc_state_t;
  localparam int COUNT_W = 16;
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/step_control_if.sv
// step_control_if: pushbuttons, halt request and processor enable/status bundle
interface step_control_if;
  import proc_ctrl_pkg::*;
  logic               key_step_n;
  logic               key_run_n;
  logic               halt_req;
  logic               cpu_en;
  proc_state_t        mode;
  logic [COUNT_W-1:0] step_count;
  modport master (output key_step_n, key_run_n, halt_req, input cpu_en, mode, step_count);
  modport slave (input key_step_n, key_run_n, halt_req, output cpu_en, mode, step_count);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchronize, debounce and detect the press edge of one active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic          sync1_q, sync2_q, stable_q, stable_d, armed_q, armed_d, done;
  logic [1:0]    fill_q;
  logic [CW-1:0] cnt_q, cnt_d;
  // synchronizer chain, stable level, run-length counter; fill/armed keep a key held through reset from firing
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      fill_q   <= '0;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      fill_q   <= {fill_q[0], 1'b1};
      armed_q  <= armed_d;
    end
  end
  // accept the new level after enough consecutive disagreeing samples; arm once a real released sample is seen
  always_comb begin
    done     = (sync2_q != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d    = (sync2_q == stable_q || done) ? '0 : cnt_q + 1'b1;
    stable_d = done ? sync2_q : stable_q;
    armed_d  = armed_q | (fill_q[1] & sync2_q);
  end
  assign press = armed_q & stable_q & ~stable_d;
endmodule

// File: rtl/step_control.sv
// step_control: single-step / free-run / halt clock-enable controller for a processor
module step_control
  import proc_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RUN_DIV         = 25000000
) (
  input logic          clock,
  input logic          reset,
  step_control_if.slave bus
);
  localparam int DW = width_for(RUN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);
  proc_state_t        state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic               cpu_en_q, cpu_en_d, cpu_en, step_ev, run_ev;
  logic [COUNT_W-1:0] count_q, count_d;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clock(clock), .reset(reset), .key_n(bus.key_step_n), .press(step_ev)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clock(clock), .reset(reset), .key_n(bus.key_run_n), .press(run_ev)
  );
  // state, divider, registered enable and step counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= STOP;
      div_q    <= '0;
      cpu_en_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cpu_en_q <= cpu_en_d;
      count_q  <= count_d;
    end
  end
  // next state: halt dominates; run beats step in STOP; RUN and HALT only leave on a run event
  always_comb begin
    state_d = bus.halt_req ? HALT :
              (state_q == STOP) ? (run_ev ? RUN : step_ev ? STEP : STOP) :
              (state_q == STEP) ? STOP :
              run_ev ? STOP : state_q;
    div_d   = (state_d == RUN && state_q == RUN && div_q != DIV_LAST) ? div_q + 1'b1 : '0;
  end
  // outputs: enable next cycle for STEP or the divider's last count; count every enable that got out
  always_comb begin
    cpu_en_d = (state_d == STEP) || (state_d == RUN && div_d == DIV_LAST);
    count_d  = count_q + COUNT_W'(cpu_en);
  end
  assign cpu_en         = cpu_en_q & ~bus.halt_req;
  assign bus.cpu_en     = cpu_en;
  assign bus.mode       = state_q;
  assign bus.step_count = count_q;
endmodule

// File: tb/tb_step_control.sv
// tb_step_control: scoreboard bench for step_control (main DUT plus a fast instance for the counter wrap)
module tb_step_control;
  import proc_ctrl_pkg::*;
  typedef struct packed {
    logic [127:0] name;
    logic [1:0]   mode;
    logic [15:0]  cnt;
    logic         from_prev;
    int           base;
    int           lat;
  } pulse_t;
  typedef struct packed {
    logic [127:0] name;
    logic         dut2;
    logic         en;
    logic [1:0]   mode;
    logic [15:0]  cnt;
  } chk_t;
  logic clock = 1'b0;
  logic reset;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int exp_cyc;
  int last_pulse = 0;
  bit drain = 0;
  bit found;
  int t0;
  pulse_t pq[$];
  chk_t cq[$];
  pulse_t p;
  chk_t ce;
  logic got_en;
  logic [1:0] got_mode;
  logic [15:0] got_cnt;
  step_control_if bus();
  step_control_if bus2();
  step_control #(.DEBOUNCE_CYCLES(4), .RUN_DIV(5)) dut (.clock(clock), .reset(reset), .bus(bus));
  step_control #(.DEBOUNCE_CYCLES(1), .RUN_DIV(1)) dut2 (.clock(clock), .reset(reset), .bus(bus2));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic expect_pulse(input logic [127:0] nm, input logic [1:0] m, input logic [15:0] c, input logic fp, input int lat);
    pq.push_back('{nm, m, c, fp, cyc, lat});
  endtask
  task automatic expect_state(input logic [127:0] nm, input logic d2, input logic e, input logic [1:0] m, input logic [15:0] c);
    cq.push_back('{nm, d2, e, m, c});
  endtask
  // monitor: every enable pulse of the main DUT is matched against the pulse queue; state checks are compared as queued
  always @(negedge clock) begin
    if (bus.cpu_en === 1'b1) begin
      vectors++;
      if (pq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse cyc=%0d got mode=%0d count=%h, required no pulse", cyc, bus.mode, bus.step_count);
      end else begin
        p = pq.pop_front();
        exp_cyc = (p.from_prev ? last_pulse : p.base) + p.lat;
        if (bus.mode !== p.mode || bus.step_count !== p.cnt || cyc != exp_cyc) begin
          miscompares++;
          $display("FAIL %0s got mode=%0d count=%h cyc=%0d, required mode=%0d count=%h cyc=%0d",
                   p.name, bus.mode, bus.step_count, cyc, p.mode, p.cnt, exp_cyc);
        end
      end
      last_pulse = cyc;
    end
    while (cq.size() > 0) begin
      ce = cq.pop_front();
      got_en   = ce.dut2 ? bus2.cpu_en : bus.cpu_en;
      got_mode = ce.dut2 ? bus2.mode : bus.mode;
      got_cnt  = ce.dut2 ? bus2.step_count : bus.step_count;
      vectors++;
      if (got_en !== ce.en || got_mode !== ce.mode || got_cnt !== ce.cnt) begin
        miscompares++;
        $display("FAIL %0s got en=%b mode=%0d count=%h, required en=%b mode=%0d count=%h",
                 ce.name, got_en, got_mode, got_cnt, ce.en, ce.mode, ce.cnt);
      end
    end
    if (drain) begin
      while (pq.size() > 0) begin
        p = pq.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL %0s got no pulse, required mode=%0d count=%h", p.name, p.mode, p.cnt);
      end
    end
  end
  initial begin
    reset = 1'b0;
    bus.key_step_n = 1'b1; bus.key_run_n = 1'b1; bus.halt_req = 1'b0;
    bus2.key_step_n = 1'b1; bus2.key_run_n = 1'b1; bus2.halt_req = 1'b0;
    expect_state("reset", 0, 0, STOP, 16'h0000);
    tick(3);
    reset = 1'b1;
    tick(6);
    t0 = cyc;
    expect_pulse("step_pulse", STEP, 16'h0000, 0, 6);
    bus.key_step_n = 1'b0; tick(20); bus.key_step_n = 1'b1; tick(10);
    expect_state("step_done", 0, 0, STOP, 16'h0001);
    bus.key_step_n = 1'b0; tick(3); bus.key_step_n = 1'b1; tick(10);
    expect_state("bounce", 0, 0, STOP, 16'h0001);
    expect_pulse("run_p1", RUN, 16'h0001, 0, 10);
    expect_pulse("run_p2", RUN, 16'h0002, 1, 5);
    expect_pulse("run_p3", RUN, 16'h0003, 1, 5);
    expect_pulse("run_p4", RUN, 16'h0004, 1, 5);
    bus.key_run_n = 1'b0; bus.key_step_n = 1'b0; tick(8);
    expect_state("run_mode", 0, 0, RUN, 16'h0001);
    bus.key_run_n = 1'b1; bus.key_step_n = 1'b1; tick(7);
    bus.key_step_n = 1'b0; tick(5); bus.key_step_n = 1'b1; tick(2);
    bus.key_run_n = 1'b0; tick(8); bus.key_run_n = 1'b1; tick(20);
    expect_state("run_stop", 0, 0, STOP, 16'h0005);
    expect_pulse("halt_pre", RUN, 16'h0005, 0, 10);
    bus.key_run_n = 1'b0; tick(8); bus.key_run_n = 1'b1; tick(7);
    bus.halt_req = 1'b1;
    expect_state("halt_gate", 0, 0, RUN, 16'h0006);
    tick(1);
    expect_state("halt_mode", 0, 0, HALT, 16'h0006);
    tick(4);
    bus.key_run_n = 1'b0; tick(8); bus.key_run_n = 1'b1; tick(4);
    expect_state("halt_run_ign", 0, 0, HALT, 16'h0006);
    bus.halt_req = 1'b0; tick(8);
    expect_state("halt_hold", 0, 0, HALT, 16'h0006);
    bus.key_run_n = 1'b0; tick(8);
    expect_state("halt_exit", 0, 0, STOP, 16'h0006);
    bus.key_run_n = 1'b1; tick(10);
    bus.key_run_n = 1'b0; tick(3); bus.key_step_n = 1'b0; tick(5);
    expect_state("rst_run_mode", 0, 0, RUN, 16'h0006);
    bus.key_run_n = 1'b1; tick(2);
    #1 reset = 1'b0;
    expect_state("rst_async", 0, 0, STOP, 16'h0000);
    tick(3); reset = 1'b1; tick(20);
    expect_state("rst_key_held", 0, 0, STOP, 16'h0000);
    bus.key_step_n = 1'b1; tick(10);
    expect_pulse("step_after_rst", STEP, 16'h0000, 0, 6);
    bus.key_step_n = 1'b0; tick(10); bus.key_step_n = 1'b1; tick(10);
    expect_state("step_after_rst_cnt", 0, 0, STOP, 16'h0001);
    bus2.key_run_n = 1'b0; tick(3); bus2.key_run_n = 1'b1;
    found = 0;
    for (int i = 0; i < 70000 && !found; i++) begin
      @(negedge clock);
      if (bus2.step_count == 16'hFFFF) begin
        bus2.halt_req = 1'b1;
        found = 1;
      end
    end
    @(posedge clock); #1;
    expect_state("wrap_halt", 1, 0, HALT, 16'hFFFF);
    bus2.halt_req = 1'b0; bus2.key_run_n = 1'b0; tick(3); bus2.key_run_n = 1'b1; tick(3);
    expect_state("wrap_stop", 1, 0, STOP, 16'hFFFF);
    bus2.key_step_n = 1'b0; tick(3); bus2.key_step_n = 1'b1; tick(5);
    expect_state("wrap_zero", 1, 0, STOP, 16'h0000);
    tick(2);
    drain = 1;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
